muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width W (even, >=8).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 The block SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports src_a, src_b  input  W  rs1 and rs2 operands, captured with start.
REQ-007 The block SHALL have port flush  input  1  abort of the in-flight operation (branch/jump redirect).
REQ-008 The block SHALL have port busy  output  1  operation in progress; execute stage stalls on it.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-010 The block SHALL have port result  output  W  result, held stable from done until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, CALC, FIX, DONE.
- IDLE->CALC on accepted start, normal path.
- IDLE->DONE on accepted start, special case (REQ-016, REQ-017).
- CALC->FIX when the iteration counter reaches W-1.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-012 Start SHALL be accepted only in IDLE with flush=0; start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-013 busy SHALL be 1 in CALC and FIX, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-014 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per cycle, into a 2W-bit product.
- Signedness per op: MULH both operands signed; MULHSU a signed, b unsigned; MULHU and MUL unsigned magnitudes.
- FIX SHALL negate the product when the sign rule requires it.
- MUL returns the low W bits; MULH, MULHSU and MULHU return the high W bits.
REQ-015 Divide SHALL be restoring division on magnitudes, one quotient bit per cycle.
- FIX SHALL apply the signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-016 Divide by zero SHALL take the fast path: quotient all-ones, remainder = src_a, for both signed and unsigned ops.
REQ-017 Signed overflow (DIV/REM, src_a = 1 followed by W-1 zeros, src_b all-ones) SHALL take the fast path: quotient = src_a, remainder = 0.
REQ-018 Latency on the normal path SHALL be W+2 rising edges from the edge accepting start to the edge entering DONE; on the fast path it SHALL be 1 edge.
REQ-019 A new start SHALL be acceptable in the cycle after DONE (back-to-back throughput of W+3 cycles).
REQ-020 flush=1 in CALC, FIX or DONE SHALL force IDLE on the next edge; done SHALL not assert for the aborted operation and result SHALL keep its previous value.
REQ-021 If flush and start are both 1 in IDLE, flush SHALL win and start SHALL be ignored.
REQ-022 The iteration counter SHALL be $clog2(W) bits wide and SHALL never wrap past W-1 within one operation.

Reset
REQ-023 When rst=0 the block SHALL asynchronously enter IDLE with busy=0, done=0, result=0, counter=0 and internal accumulators=0.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow after reset release.
REQ-025 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-026 A shared package muldiv_pkg SHALL hold the op enum (funct3 encoding) and the state enum, so the decoder can import them.
REQ-027 The block SHALL be a single module with no sub-module; a separate datapath module is not warranted.

Verification
REQ-028 The bench SHALL cover these scenarios (W=32):
- MUL 7 x 6: done exactly 34 edges after start; result 42.
- MULH 0x80000000 x 0x80000000: result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF: result 0xFFFFFFFE.
- DIV -7/2: result 0xFFFFFFFD. REM -7/2: result 0xFFFFFFFF. DIVU 100/7: result 14. REMU 100/7: result 2.
- DIVU 5/0: result 0xFFFFFFFF; REM 5/0: result 5; DIV 0x80000000/0xFFFFFFFF: result 0x80000000; all with done 1 edge after start.
- Flush at CALC cycle 10: IDLE next edge, no done, result unchanged; a start asserted during busy shows no effect.
- rst low mid-CALC: busy=0, done=0, result=0 immediately; a back-to-back start after release completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the RV32M funct3 operation encoding and the control FSM state
// encoding so that the decoder and the unit agree on both. It also holds
// the per-operation signedness helpers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } opE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } stateE;

   // funct3[2] separates the divide family from the multiply family.
   function automatic logic isDivOp(input opE o);
      return o[2];
   endfunction

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic aIsSigned(input opE o);
      return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic bIsSigned(input opE o);
      return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division. Both work on
// operand magnitudes and produce one bit per cycle. The signs are applied
// in a final FIX cycle. Divide-by-zero and signed overflow skip the
// iteration and complete on the accepting edge.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous active-low reset
//   start   request, accepted only in IDLE with flush low
//   op      RV32M funct3
//   src_a   rs1 operand (dividend / multiplier)
//   src_b   rs2 operand (divisor / multiplicand)
//   flush   abort of the in-flight operation
//   busy    high in CALC and FIX
//   done    one-cycle pulse in DONE, result valid
//   result  held from done until the next accepted start
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
   localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

   function automatic logic [W-1:0] negIf(input logic [W-1:0] v, input logic n);
      logic signed [W-1:0] s;
      s = $signed(v);
      return n ? -s : v;
   endfunction

   function automatic logic [2*W-1:0] negIfWide(input logic [2*W-1:0] v, input logic n);
      logic signed [2*W-1:0] s;
      s = $signed(v);
      return n ? -s : v;
   endfunction

   stateE          state;
   opE             opQ;
   logic [CW-1:0]  iterCnt;
   logic [W-1:0]   opB;        // multiplicand or divisor magnitude
   logic [2*W-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
   logic           negMain;    // negate product / quotient in FIX
   logic           negRem;     // negate remainder in FIX

   opE             opIn;
   logic           aNegIn, bNegIn;
   logic [W-1:0]   absAIn, absBIn;
   logic           divZero, divOvf;
   logic [W-1:0]   fastRes;
   logic [W:0]     mulSum, divShift, divDiff;
   logic [2*W-1:0] accStep, prodFix;
   logic [W-1:0]   fixRes;

   always_comb begin
      opIn    = opE'(op);
      aNegIn  = aIsSigned(opIn) & src_a[W-1];
      bNegIn  = bIsSigned(opIn) & src_b[W-1];
      absAIn  = negIf(src_a, aNegIn);
      absBIn  = negIf(src_b, bNegIn);
      divZero = isDivOp(opIn) && (src_b == '0);
      divOvf  = ((opIn == OP_DIV) || (opIn == OP_REM)) && (src_a == MOST_NEG) && (src_b == '1);
      // op[1] selects the remainder in the divide family.
      if (divZero) fastRes = opIn[1] ? src_a : '1;
      else         fastRes = opIn[1] ? '0 : src_a;

      // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
      mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opB} : {(W+1){1'b0}});
      // Restoring step: shift in next dividend bit, keep the difference if non-negative.
      divShift = acc[2*W-1:W-1];
      divDiff  = divShift - {1'b0, opB};
      if (isDivOp(opQ)) begin
         if (!divDiff[W]) accStep = {divDiff[W-1:0], acc[W-2:0], 1'b1};
         else             accStep = {divShift[W-1:0], acc[W-2:0], 1'b0};
      end else begin
         accStep = {mulSum, acc[W-1:1]};
      end

      prodFix = negIfWide(acc, negMain);
      unique case (opQ)
         OP_MUL:                       fixRes = prodFix[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[2*W-1:W];
         OP_DIV, OP_DIVU:              fixRes = negIf(acc[W-1:0], negMain);
         default:                      fixRes = negIf(acc[2*W-1:W], negRem);
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         iterCnt <= '0;
         acc     <= '0;
         opB     <= '0;
         opQ     <= OP_MUL;
         negMain <= 1'b0;
         negRem  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !flush) begin
                  opQ     <= opIn;
                  iterCnt <= '0;
                  if (divZero || divOvf) begin
                     result <= fastRes;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     acc     <= {{W{1'b0}}, absAIn};
                     opB     <= absBIn;
                     negMain <= aNegIn ^ bNegIn;
                     negRem  <= aNegIn;
                     busy    <= 1'b1;
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc <= accStep;
                  // Counter parks at W-1 rather than wrapping.
                  if (iterCnt == LAST_ITER) state <= FIX;
                  else                      iterCnt <= iterCnt + 1'b1;
               end
            end
            FIX: begin
               busy <= 1'b0;
               if (flush) begin
                  state <= IDLE;
               end else begin
                  result <= fixRes;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] lastRes = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference results from plain 64-bit arithmetic on the RV32M definitions.
   function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, sp;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      up = {32'b0, a} * {32'b0, b};
      case (f)
         3'd0: return up[31:0];
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * ub; return sp[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            sp = sa / sb; return sp[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sp = sa % sb; return sp[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
   endfunction

   // Drives start now, then follows the operation through DONE and one more edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
      int edges;
      start = 1'b1; op = f; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      while (done !== 1'b1 && edges < 200) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, "_lat"}, edges, refLatency(f, a, b));
      chk({tag, "_res"}, result, exp);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done, 1'b0);
      chk({tag, "_hold"}, result, exp);
      lastRes = exp;
   endtask

   task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
      @(negedge clk);
      issue(f, a, b, exp, tag);
   endtask

   initial begin
      int edges;
      int sawDone;
      logic [2:0]  f;
      logic [31:0] a, b;
      int mode;

      rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases
      runOp(3'd0, 32'd7, 32'd6, 32'd42, "mul7x6");
      runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
      runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
      runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      runOp(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      runOp(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
      runOp(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
      runOp(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
      runOp(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
      runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");

      // Flush at CALC cycle 10
      @(negedge clk);
      start = 1'b1; op = 3'd0; src_a = 32'd123; src_b = 32'd456;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", busy, 1'b0);
      chk("flush_done", done, 1'b0);
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) sawDone++;
      end
      chk("flush_nodone", sawDone, 0);
      chk("flush_result", result, lastRes);

      // Flush and start together in IDLE: start ignored
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flushstart_busy", busy, 1'b0);
      chk("flushstart_done", done, 1'b0);
      chk("flushstart_result", result, lastRes);

      // Start pulses while busy must not disturb the operation in flight
      @(negedge clk);
      start = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      edges = 1;
      while (done !== 1'b1 && edges < 200) begin
         @(negedge clk);
         start = (edges >= 5 && edges < 8);
         op = 3'd0; src_a = 32'd5; src_b = 32'd5;
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      chk("busystart_lat", edges, W + 2);
      chk("busystart_res", result, refResult(3'd4, 32'd1000, 32'hFFFF_FFFD));
      @(posedge clk); #1;
      lastRes = refResult(3'd4, 32'd1000, 32'hFFFF_FFFD);

      // Reset in the middle of CALC
      @(negedge clk);
      start = 1'b1; op = 3'd5; src_a = 32'd77777; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      issue(3'd6, 32'hFFFF_FF9C, 32'd7, refResult(3'd6, 32'hFFFF_FF9C, 32'd7), "after_rst");
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, refResult(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), "b2b");

      // Randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         mode = $urandom_range(0, 15);
         if (mode == 0) b = 32'h0;
         else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (mode <= 4) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         runOp(f, a, b, refResult(f, a, b), $sformatf("rnd%0d_op%0d", i, f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
